matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader.sv | 175 +++++++++++++++++
 tb/tb_matrix_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// matrix_loader
//   Accepts a 32-byte frame of unsigned 8-bit matrix elements (A then B, both
//   row-major 4x4) and writes them into the shared A/B word memory:
//   A rows packed as words at BASE_A+row, B columns packed as words at
//   BASE_B+col. It then kicks the matmul engine and reports completion.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : byte stream in (s_last on byte 31 only)
//   mem_write_en, mem_addr, mem_data : word write port to A/B memory
//   kick_start    : one-cycle start pulse to the engine
//   mm_ready      : engine idle/ready
//   busy          : low only when idle in LOAD_A with no bytes received
//   done          : one-cycle pulse when the engine finishes after a kick
//   err           : one-cycle pulse on a frame-length error
module matrix_loader #(
  parameter logic [9:0] BASE_A = 10'h000,
  parameter logic [9:0] BASE_B = 10'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        mem_write_en,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_data,
  output logic        kick_start,
  input  logic        mm_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    WRITE_B,
    KICK,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [7:0]  pack [4];
  logic [7:0]  bbuf [4][4];
  logic        we_q;
  logic        kick_q;
  logic        done_q;
  logic        err_q;
  logic [9:0]  addr_q;
  logic [31:0] data_q;
  logic        accept;
  logic        last_bad;

  // One B column as a memory word: row 0 in the low byte.
  function automatic logic [31:0] col_word(input logic [1:0] c);
    return {bbuf[3][c], bbuf[2][c], bbuf[1][c], bbuf[0][c]};
  endfunction

  assign s_ready  = ~rst & (((state == LOAD_A) & mm_ready) | (state == LOAD_B));
  assign accept   = s_valid & s_ready;
  // s_last must be set on byte 31 and on no other byte.
  assign last_bad = s_last != (cnt == 5'd31);

  // Outputs are forced low while rst is held so that a reset arriving in
  // the middle of WRITE_B cannot let another word reach the memory.
  assign mem_write_en = ~rst & we_q;
  assign mem_addr     = rst ? 10'd0 : addr_q;
  assign mem_data     = rst ? 32'd0 : data_q;
  assign kick_start   = ~rst & kick_q;
  assign done         = ~rst & done_q;
  assign err          = ~rst & err_q;
  assign busy         = ~rst & ~((state == LOAD_A) && (cnt == 5'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD_A;
      cnt    <= 5'd0;
      we_q   <= 1'b0;
      kick_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= 10'd0;
      data_q <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        pack[i] <= 8'd0;
        for (int j = 0; j < 4; j++) bbuf[i][j] <= 8'd0;
      end
    end else begin
      we_q   <= 1'b0;
      kick_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        LOAD_A: begin
          if (accept) begin
            if (last_bad) begin
              // Bad frame: the row that this byte would complete is not written.
              err_q <= 1'b1;
              cnt   <= 5'd0;
              for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) bbuf[i][j] <= 8'd0;
            end else begin
              pack[cnt[1:0]] <= s_data;
              cnt            <= cnt + 5'd1;
              if (cnt[1:0] == 2'd3) begin
                we_q   <= 1'b1;
                addr_q <= BASE_A + {8'd0, cnt[3:2]};
                data_q <= {s_data, pack[2], pack[1], pack[0]};
              end
              if (cnt == 5'd15) state <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (last_bad) begin
              err_q <= 1'b1;
              cnt   <= 5'd0;
              state <= LOAD_A;
              for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) bbuf[i][j] <= 8'd0;
            end else begin
              bbuf[cnt[3:2]][cnt[1:0]] <= s_data;
              // Wraps 31 -> 0 so cnt[1:0] can serve as the column index below.
              cnt <= cnt + 5'd1;
              if (cnt == 5'd31) begin
                // Column 0 never includes byte 31 (B[3][3]), so it can be
                // issued now and is visible in the first WRITE_B cycle.
                state  <= WRITE_B;
                we_q   <= 1'b1;
                addr_q <= BASE_B;
                data_q <= col_word(2'd0);
              end
            end
          end
        end
        WRITE_B: begin
          // cnt[1:0] is the column currently on the write port.
          if (cnt[1:0] == 2'd3) begin
            state  <= KICK;
            kick_q <= 1'b1;
            cnt    <= 5'd0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= BASE_B + {8'd0, cnt[1:0] + 2'd1};
            data_q <= col_word(cnt[1:0] + 2'd1);
            cnt    <= cnt + 5'd1;
          end
        end
        KICK: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!mm_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mm_ready) begin
            state  <= LOAD_A;
            cnt    <= 5'd0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= LOAD_A;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Testbench for matrix_loader: frames are driven with random stalls, expected
// memory writes / kick / done / err events are queued from a plain model of
// the frame layout, and a monitor process pops and compares them.
module tb_matrix_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        eng_ready = 1'b1;
  logic        hold_low = 1'b0;
  logic        mm_ready;
  logic        s_ready;
  logic        mem_write_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        kick_start;
  logic        busy;
  logic        done;
  logic        err;

  assign mm_ready = eng_ready & ~hold_low;

  matrix_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .kick_start(kick_start),
    .mm_ready(mm_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  localparam int EV_WRITE = 0;
  localparam int EV_KICK  = 1;
  localparam int EV_ERR   = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fr [32];

  function automatic string kname(int k);
    case (k)
      EV_WRITE: return "write";
      EV_KICK:  return "kick";
      EV_ERR:   return "err";
      default:  return "done";
    endcase
  endfunction

  task automatic push(int kind, logic [9:0] a, logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic check_ev(int kind, logic [9:0] a, logic [31:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got addr=%h data=%h, required no event", kname(kind), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_WRITE && (e.addr !== a || e.data !== d))) begin
        errors++;
        $display("FAIL event got %s addr=%h data=%h, required %s addr=%h data=%h",
                 kname(kind), a, d, kname(e.kind), e.addr, e.data);
      end
    end
  endtask

  // Monitor: compares every observed event against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_write_en) check_ev(EV_WRITE, mem_addr, mem_data);
      if (kick_start)   check_ev(EV_KICK, 10'd0, 32'd0);
      if (done) begin
        check_ev(EV_DONE, 10'd0, 32'd0);
        chk("done_s_ready", {31'd0, s_ready}, 32'd1);
      end
      if (err)          check_ev(EV_ERR, 10'd0, 32'd0);
    end
  end

  // Engine: drops ready 2 cycles after a kick, raises it 20 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (kick_start) begin
        repeat (2) @(posedge clk);
        #1 eng_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 eng_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic send_byte(logic [7:0] d, logic l, int stall_pct);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < stall_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
      end
      #1 acc = s_valid && s_ready;
      @(posedge clk);
      guard++;
      if (!acc && guard > 300) begin
        checks++;
        errors++;
        $display("FAIL byte_accept got=not_accepted required=accepted");
        break;
      end
    end
    #1 s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  // Model: A row r word = elements 4r..4r+3, element j in byte lane j.
  // B column c word = B[i][c] = frame byte 16+4i+c in byte lane i.
  task automatic expect_frame(int err_at);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) begin
      if (err_at < 0 || 4 * r + 3 < err_at) begin
        w = 32'd0;
        for (int j = 0; j < 4; j++) w = w | (32'(fr[4 * r + j]) << (8 * j));
        push(EV_WRITE, 10'h000 + 10'(r), w);
      end
    end
    if (err_at >= 0) begin
      push(EV_ERR, 10'd0, 32'd0);
    end else begin
      for (int c = 0; c < 4; c++) begin
        w = 32'd0;
        for (int i = 0; i < 4; i++) w = w | (32'(fr[16 + 4 * i + c]) << (8 * i));
        push(EV_WRITE, 10'h100 + 10'(c), w);
      end
      push(EV_KICK, 10'd0, 32'd0);
      push(EV_DONE, 10'd0, 32'd0);
    end
  endtask

  task automatic send_frame(int err_at, int stall_pct);
    int  n;
    logic l;
    expect_frame(err_at);
    n = (err_at >= 0) ? err_at + 1 : 32;
    for (int k = 0; k < n; k++) begin
      l = (k == 31);
      if (k == err_at) l = ~l;
      send_byte(fr[k], l, stall_pct);
    end
  endtask

  task automatic wait_drain(string name, int maxc);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      @(posedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic fill_ident();
    for (int k = 0; k < 16; k++) fr[k] = 8'(k + 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) fr[16 + 4 * i + j] = (i == j) ? 8'd1 : 8'd0;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++) fr[k] = 8'($urandom_range(255));
  endtask

  task automatic check_all_zero(string name);
    chk({name, "_we"},   {31'd0, mem_write_en}, 32'd0);
    chk({name, "_kick"}, {31'd0, kick_start}, 32'd0);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    chk({name, "_err"},  {31'd0, err}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_addr"}, {22'd0, mem_addr}, 32'd0);
    chk({name, "_data"}, mem_data, 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");
    chk("after_reset_s_ready", {31'd0, s_ready}, 32'd1);

    // A = 1..16, B = identity, no stalls
    fill_ident();
    send_frame(-1, 0);
    wait_drain("ident", 200);

    // Same frame with random stalls
    send_frame(-1, 50);
    wait_drain("ident_stall", 400);

    // Engine not ready at frame start: nothing accepted
    hold_low = 1'b1;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = fr[0];
    s_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd0);
    end
    s_valid = 1'b0;
    hold_low = 1'b0;
    send_frame(-1, 0);
    wait_drain("after_hold", 200);

    // Early s_last on byte 5, then a good frame
    send_frame(5, 0);
    wait_drain("err5", 100);
    send_frame(-1, 20);
    wait_drain("after_err5", 300);

    // Missing s_last on byte 31
    fill_rand();
    send_frame(31, 30);
    wait_drain("err31", 200);

    // Random frames, random stall rates
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      send_frame(-1, int'($urandom_range(60)));
      wait_drain("rand", 400);
    end

    // Reset during the second WRITE_B cycle: only column 0 of B lands
    fill_rand();
    expect_frame(-1);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    for (int k = 0; k < 32; k++) send_byte(fr[k], (k == 31), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("wb_reset");
    repeat (40) @(posedge clk);
    wait_drain("wb_reset", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
